// File: rtl/dm_pkg.sv
// Shared load/store definitions: op encodings, load FSM states and lane-select helpers.
// Also used by the store aligner.
package dm_pkg;

  typedef enum logic [2:0] {
    LD_NONE = 3'd0,
    LD_W    = 3'd1,
    LD_H    = 3'd2,
    LD_HU   = 3'd3,
    LD_B    = 3'd4,
    LD_BU   = 3'd5
  } ld_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } ld_state_e;

  function automatic logic is_load(input logic [2:0] op);
    return (op >= 3'd1) && (op <= 3'd5);
  endfunction

  function automatic logic [7:0] byte_lane(input logic [31:0] w, input logic [1:0] k);
    logic [7:0] b;
    case (k)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    return b;
  endfunction

  function automatic logic [15:0] half_lane(input logic [31:0] w, input logic h);
    return h ? w[31:16] : w[15:0];
  endfunction

  function automatic logic misaligned(input logic [2:0] op, input logic [1:0] off);
    return ((op == 3'd1) && (off != 2'd0)) ||
           (((op == 3'd2) || (op == 3'd3)) && off[0]);
  endfunction

endpackage

// File: rtl/dm_load_unit_if.sv
// Data-memory read bus between the load unit (master) and the memory (slave).
interface dm_load_unit_if #(
  parameter int ADDR_W = 16
);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_rdata,
    input  mem_ack
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_rdata,
    output mem_ack
  );
endinterface

// File: rtl/dm_load_unit_extract.sv
// Combinational lane selection and sign/zero extension of a loaded word.
module load_extract
  import dm_pkg::*;
(
  input  ld_op_e      op,
  input  logic [1:0]  off,
  input  logic [31:0] rdata,
  output logic [31:0] result
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = byte_lane(rdata, off);
    h = half_lane(rdata, off[1]);
    case (op)
      LD_W:    result = rdata;
      LD_H:    result = {{16{h[15]}}, h};
      LD_HU:   result = {16'h0000, h};
      LD_B:    result = {{24{b[7]}}, b};
      LD_BU:   result = {24'h000000, b};
      default: result = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/dm_load_unit.sv
// M-stage load unit: one outstanding aligned read, watchdog abort, extended result.
// Define DM_ALIGN_EXC_EN to trap misaligned lw/lh/lhu instead of issuing them.
module dm_load_unit
  import dm_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld_valid,
  input  logic [2:0]        ld_op,
  input  logic [ADDR_W-1:0] ld_addr,
  dm_load_unit_if.master    mem,
  output logic [31:0]       ld_out,
  output logic              ld_done,
  output logic              ld_err,
  output logic              stall
`ifdef DM_ALIGN_EXC_EN
  ,
  output logic              ld_exc
`endif
);

  localparam int WD_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  ld_state_e         state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       ld_out_q, ld_out_d;
  logic              ld_done_q, ld_done_d;
  logic              ld_err_q, ld_err_d;
  logic [WD_W-1:0]   wdog_q, wdog_d;
  ld_op_e            op_q, op_d;
  logic [1:0]        off_q, off_d;
  logic              accept;
  logic              align_fault;
  logic [31:0]       ext_res;

  load_extract u_extract (
    .op     (op_q),
    .off    (off_q),
    .rdata  (mem.mem_rdata),
    .result (ext_res)
  );

  assign accept = ld_valid && is_load(ld_op);

`ifdef DM_ALIGN_EXC_EN
  logic ld_exc_q, ld_exc_d;
  assign align_fault = misaligned(ld_op, ld_addr[1:0]);
  assign ld_exc_d    = (state_q == S_IDLE) && accept && align_fault;
  assign ld_exc      = ld_exc_q;

  always_ff @(posedge clk) begin
    if (reset) ld_exc_q <= 1'b0;
    else       ld_exc_q <= ld_exc_d;
  end
`else
  assign align_fault = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    ld_out_d   = ld_out_q;
    ld_done_d  = 1'b0;
    ld_err_d   = 1'b0;
    wdog_d     = wdog_q;
    op_d       = op_q;
    off_d      = off_q;
    stall      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          stall = 1'b1;
          op_d  = ld_op_e'(ld_op);
          off_d = ld_addr[1:0];
          if (align_fault) begin
            state_d   = S_DONE;
            ld_done_d = 1'b1;
            ld_out_d  = 32'h0000_0000;
          end else begin
            state_d    = S_REQ;
            mem_req_d  = 1'b1;
            mem_addr_d = {ld_addr[ADDR_W-1:2], 2'b00};
            wdog_d     = '0;
          end
        end
      end
      S_REQ: begin
        stall = 1'b1;
        // An ack in the final watchdog cycle still completes the load normally.
        if (mem.mem_ack) begin
          state_d   = S_DONE;
          mem_req_d = 1'b0;
          ld_done_d = 1'b1;
          ld_out_d  = ext_res;
        end else if (wdog_q == WD_LAST) begin
          state_d   = S_DONE;
          mem_req_d = 1'b0;
          ld_done_d = 1'b1;
          ld_err_d  = 1'b1;
          ld_out_d  = 32'h0000_0000;
        end else begin
          wdog_d = wdog_q + WD_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      ld_out_q   <= 32'h0000_0000;
      ld_done_q  <= 1'b0;
      ld_err_q   <= 1'b0;
      wdog_q     <= '0;
    end else begin
      state_q    <= state_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      ld_out_q   <= ld_out_d;
      ld_done_q  <= ld_done_d;
      ld_err_q   <= ld_err_d;
      wdog_q     <= wdog_d;
    end
  end

  // Latched op/offset only matter while a load is in flight.
  always_ff @(posedge clk) begin
    op_q  <= op_d;
    off_q <= off_d;
  end

  assign mem.mem_req  = mem_req_q;
  assign mem.mem_addr = mem_addr_q;
  assign ld_out       = ld_out_q;
  assign ld_done      = ld_done_q;
  assign ld_err       = ld_err_q;

endmodule

// File: tb/tb_dm_load_unit.sv
// Scoreboard bench for dm_load_unit: expected completions queued at accept, checked on ld_done.
module tb_dm_load_unit;

  localparam int TO = 15;

  typedef struct {
    logic [31:0] out;
    logic        err;
    logic        exc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        ld_valid;
  logic [2:0]  ld_op;
  logic [15:0] ld_addr;
  logic [31:0] ld_out;
  logic        ld_done;
  logic        ld_err;
  logic        stall;
`ifdef DM_ALIGN_EXC_EN
  logic        ld_exc;
`endif

  int n_chk  = 0;
  int n_fail = 0;
  exp_t exp_q[$];

  dm_load_unit_if #(.ADDR_W(16)) bus ();

  dm_load_unit #(.ADDR_W(16), .TIMEOUT(TO)) dut (
    .clk      (clk),
    .reset    (reset),
    .ld_valid (ld_valid),
    .ld_op    (ld_op),
    .ld_addr  (ld_addr),
    .mem      (bus),
    .ld_out   (ld_out),
    .ld_done  (ld_done),
    .ld_err   (ld_err),
    .stall    (stall)
`ifdef DM_ALIGN_EXC_EN
    ,
    .ld_exc   (ld_exc)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] op, input logic [1:0] a, input logic [31:0] w);
    logic [31:0] sb, sh;
    sb = w >> (8 * a);
    sh = w >> (16 * a[1]);
    case (op)
      3'd1:    return w;
      3'd2:    return {{16{sh[15]}}, sh[15:0]};
      3'd3:    return {16'h0, sh[15:0]};
      3'd4:    return {{24{sb[7]}}, sb[7:0]};
      3'd5:    return {24'h0, sb[7:0]};
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit tb_misal(input logic [2:0] op, input logic [1:0] a);
`ifdef DM_ALIGN_EXC_EN
    return ((op == 3'd1) && (a != 2'd0)) || (((op == 3'd2) || (op == 3'd3)) && a[0]);
`else
    return 1'b0;
`endif
  endfunction

  always @(negedge clk) begin
    if (ld_done) begin
      if (exp_q.size() == 0) begin
        chk("spurious_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("ld_out", ld_out, e.out);
        chk("ld_err", {31'd0, ld_err}, {31'd0, e.err});
`ifdef DM_ALIGN_EXC_EN
        chk("ld_exc", {31'd0, ld_exc}, {31'd0, e.exc});
`endif
      end
    end
  end

  // lat: REQ cycles before ack (0 = ack in the first REQ cycle); negative = never ack.
  task automatic do_load(input logic [2:0] op, input logic [15:0] addr, input logic [31:0] rd,
                         input int lat, input bit noise, input bit stale);
    exp_t e;
    bit   exc, done;
    int   cyc, nreq, nst, exp_cyc, exp_req;
    exc     = tb_misal(op, addr[1:0]);
    e.exc   = exc;
    e.err   = !exc && (lat < 0);
    e.out   = (exc || lat < 0) ? 32'h0 : model(op, addr[1:0], rd);
    exp_cyc = exc ? 1 : (lat < 0 ? TO + 1 : lat + 2);
    exp_req = exc ? 0 : (lat < 0 ? TO : lat + 1);
    exp_q.push_back(e);
    ld_valid = 1'b1;
    ld_op    = op;
    ld_addr  = addr;
    #1;
    chk("accept_stall", {31'd0, stall}, 32'd1);
    @(posedge clk); #1;
    cyc = 1; nreq = 0; nst = 0; done = 0;
    while (!done && cyc <= TO + 5) begin
      if (ld_done) begin
        done = 1;
        chk("done_latency", cyc, exp_cyc);
        chk("done_stall", {31'd0, stall}, 32'd0);
        chk("done_req", {31'd0, bus.mem_req}, 32'd0);
        ld_valid    = 1'b0;
        bus.mem_ack = stale;
      end else begin
        if (stall) nst++;
        if (bus.mem_req) begin
          nreq++;
          chk("mem_addr", {16'd0, bus.mem_addr}, {16'd0, addr[15:2], 2'b00});
        end
        bus.mem_ack   = (lat >= 0) && (cyc - 1 == lat);
        bus.mem_rdata = bus.mem_ack ? rd : $urandom;
        ld_valid      = noise;
        ld_op         = 3'd5;
        ld_addr       = 16'($urandom);
        @(posedge clk); #1;
        cyc++;
      end
    end
    if (!done) chk("done_seen", 32'd0, 32'd1);
    chk("req_cycles", nreq, exp_req);
    chk("stall_cycles", nst, exp_req);
    @(posedge clk); #1;
    chk("idle_no_done", {31'd0, ld_done}, 32'd0);
    if (stale) begin
      @(posedge clk); #1;
      bus.mem_ack = 1'b0;
      chk("stale_no_req", {31'd0, bus.mem_req}, 32'd0);
      chk("stale_hold", ld_out, e.out);
    end
    bus.mem_ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got 0x00000000 expected 0x00000001");
    $fatal(1, "bench timeout");
  end

  initial begin
    reset = 1'b1; ld_valid = 1'b0; ld_op = 3'd0; ld_addr = 16'h0;
    bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
    chk("rst_mem_addr", {16'd0, bus.mem_addr}, 32'd0);
    chk("rst_ld_out", ld_out, 32'd0);
    chk("rst_ld_done", {31'd0, ld_done}, 32'd0);
    chk("rst_ld_err", {31'd0, ld_err}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
`ifdef DM_ALIGN_EXC_EN
    chk("rst_ld_exc", {31'd0, ld_exc}, 32'd0);
`endif
    reset = 1'b0;
    @(posedge clk); #1;

    do_load(3'd1, 16'h0010, 32'h1234_5678, 0, 1'b0, 1'b0);
    do_load(3'd4, 16'h0007, 32'h80FF_1234, 0, 1'b0, 1'b0);
    do_load(3'd5, 16'h0007, 32'h80FF_1234, 1, 1'b1, 1'b0);
    do_load(3'd4, 16'h0004, 32'h80FF_1234, 0, 1'b0, 1'b0);
    do_load(3'd2, 16'h0002, 32'h8001_7FFF, 2, 1'b1, 1'b0);
    do_load(3'd3, 16'h0002, 32'h8001_7FFF, 2, 1'b0, 1'b0);
    do_load(3'd1, 16'h0024, 32'hCAFE_F00D, TO - 1, 1'b0, 1'b0);
    do_load(3'd1, 16'h0020, 32'hDEAD_BEEF, -1, 1'b1, 1'b1);
    do_load(3'd1, 16'h0002, 32'hA5A5_0F0F, 0, 1'b0, 1'b0);
    do_load(3'd2, 16'h0005, 32'h1357_9BDF, 1, 1'b0, 1'b0);

    // Non-load ops with ld_valid: nothing happens.
    for (int i = 0; i < 3; i++) begin
      ld_valid = 1'b1;
      ld_op    = (i == 0) ? 3'd0 : 3'(5 + i);
      ld_addr  = 16'h0100;
      #1;
      chk("noop_stall", {31'd0, stall}, 32'd0);
      @(posedge clk); #1;
      chk("noop_req", {31'd0, bus.mem_req}, 32'd0);
    end
    ld_valid = 1'b0;

    // Reset two cycles into REQ, with a stale ack afterwards.
    ld_valid = 1'b1; ld_op = 3'd1; ld_addr = 16'h0040;
    @(posedge clk); #1;
    ld_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midrst_req", {31'd0, bus.mem_req}, 32'd0);
    chk("midrst_stall", {31'd0, stall}, 32'd0);
    chk("midrst_out", ld_out, 32'd0);
    bus.mem_ack = 1'b1;
    @(posedge clk); #1;
    bus.mem_ack = 1'b0;
    chk("midrst_no_done", {31'd0, ld_done}, 32'd0);
    chk("midrst_stale_req", {31'd0, bus.mem_req}, 32'd0);
    do_load(3'd1, 16'h0044, 32'h0BAD_F00D, 0, 1'b0, 1'b0);

    for (int i = 0; i < 24; i++) begin
      do_load(3'($urandom_range(1, 5)), 16'($urandom), $urandom,
              int'($urandom_range(0, 3)), 1'($urandom), 1'b0);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
